datapath_sequencer: RTL

//   Multi-cycle microsequencer that drives the X/Y/Z/ALU datapath from the

---
 rtl/datapath_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/datapath_sequencer.sv
// Microsequencer driving the X/Y/Z/ALU datapath from program memory.
// Optional SEQ_SINGLE_STEP_EN adds a `step` input gating each fetch.
module datapath_sequencer #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic          step,
`endif
    input  logic [DW-1:0] mem_data,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] Tx,
    output logic [DW-1:0] Ty,
    output logic [DW-1:0] Tz,
    output logic [DW-1:0] Tula,
    output logic          busy,
    output logic          halted,
    output logic          illegal
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_OPERAND = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_STORE   = 3'd5;
    localparam logic [2:0] S_CLEAR   = 3'd6;
    localparam logic [2:0] S_HALT    = 3'd7;

    localparam logic [DW-1:0] OP_NOP = DW'(0);
    localparam logic [DW-1:0] OP_LDX = DW'(1);
    localparam logic [DW-1:0] OP_ADD = DW'(2);
    localparam logic [DW-1:0] OP_SUB = DW'(3);
    localparam logic [DW-1:0] OP_AND = DW'(4);
    localparam logic [DW-1:0] OP_OR  = DW'(5);
    localparam logic [DW-1:0] OP_STZ = DW'(6);
    localparam logic [DW-1:0] OP_CLR = DW'(7);
    localparam logic [DW-1:0] OP_HLT = DW'(15);

    localparam logic [DW-1:0] C_HOLD = DW'(0);
    localparam logic [DW-1:0] C_LOAD = DW'(1);
    localparam logic [DW-1:0] C_CLR  = DW'(2);

    logic [2:0]    state;
    logic [2:0]    nstate;
    logic [DW-1:0] instr;
    logic          go;
    logic          restart;
    logic          fetch_adv;
    logic          bad_op;

`ifdef SEQ_SINGLE_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    assign restart   = start && (state == S_IDLE || state == S_HALT);
    assign fetch_adv = (state == S_FETCH) && go;

    always_comb begin
        nstate = state;
        bad_op = 1'b0;
        case (state)
            S_IDLE, S_HALT: if (start) nstate = S_FETCH;
            S_FETCH:        if (go) nstate = S_DECODE;
            S_DECODE: begin
                case (instr)
                    OP_LDX:                        nstate = S_OPERAND;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: nstate = S_EXEC;
                    OP_STZ:                        nstate = S_STORE;
                    OP_CLR:                        nstate = S_CLEAR;
                    OP_HLT:                        nstate = S_HALT;
                    OP_NOP:                        nstate = S_FETCH;
                    default: begin
                        nstate = S_FETCH;
                        bad_op = 1'b1;
                    end
                endcase
            end
            default: nstate = S_FETCH;
        endcase
    end

    // Control codes are computed from the next state so they are
    // registered and valid exactly during the cycle spent in that state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            instr   <= '0;
            Tx      <= C_HOLD;
            Ty      <= C_HOLD;
            Tz      <= C_HOLD;
            Tula    <= '0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state  <= nstate;
            busy   <= (nstate != S_IDLE) && (nstate != S_HALT);
            halted <= (nstate == S_HALT);
            Tx     <= (nstate == S_OPERAND) ? C_LOAD :
                      (nstate == S_CLEAR)   ? C_CLR  : C_HOLD;
            Ty     <= (nstate == S_EXEC)    ? C_LOAD :
                      (nstate == S_CLEAR)   ? C_CLR  : C_HOLD;
            Tz     <= (nstate == S_STORE)   ? C_LOAD :
                      (nstate == S_CLEAR)   ? C_CLR  : C_HOLD;
            if (nstate == S_EXEC) Tula <= instr - OP_ADD;
            if (fetch_adv) instr <= mem_data;
            if (restart) pc <= '0;
            else if (fetch_adv || state == S_OPERAND) pc <= pc + 1'b1;
            if (restart) illegal <= 1'b0;
            else if (bad_op) illegal <= 1'b1;
        end
    end

endmodule
